// File: rtl/msrv32_reg_file_sb.sv
// msrv32 integer register file with write-back scoreboard and issue hazard stall.
// Optional macro MSRV32_RF_BYPASS_EN: same-cycle write-back forwarding to reads and busy.

module msrv32_rf_entry #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            we_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic            clr_i,
  input  logic            set_i,
  output logic [XLEN-1:0] data_o,
  output logic            busy_o
);
  logic [XLEN-1:0] data_q;
  logic            busy_q, busy_d;

  // A new producer issuing this cycle outranks the write-back of the old one.
  assign busy_d = set_i | (busy_q & ~clr_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
      busy_q <= 1'b0;
    end else begin
      if (we_i) data_q <= wdata_i;
      busy_q <= busy_d;
    end
  end

  assign data_o = data_q;
  assign busy_o = busy_q;
endmodule

module msrv32_reg_file_sb #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic [ADDR_W-1:0]     rs_1_addr_in,
  input  logic [ADDR_W-1:0]     rs_2_addr_in,
  input  logic                  rs_1_used_in,
  input  logic                  rs_2_used_in,
  output logic [XLEN-1:0]       rs_1_out,
  output logic [XLEN-1:0]       rs_2_out,
  input  logic                  issue_valid_in,
  input  logic                  issue_rd_we_in,
  input  logic [ADDR_W-1:0]     issue_rd_addr_in,
  output logic                  stall_out,
  input  logic                  wr0_en_in,
  input  logic [ADDR_W-1:0]     wr0_addr_in,
  input  logic [XLEN-1:0]       wr0_data_in,
  input  logic                  wr1_en_in,
  input  logic [ADDR_W-1:0]     wr1_addr_in,
  input  logic [XLEN-1:0]       wr1_data_in,
  output logic [(1<<ADDR_W)-1:0] busy_out,
  output logic [31:0]           stall_count_out
);
  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0][XLEN-1:0] regs;
  logic [NREG-1:0]           busy, clr, eff_busy;
  logic                      wr0_ok, wr1_ok, issue_set;
  logic [31:0]               cnt_q, cnt_d;

  assign wr0_ok    = wr0_en_in & (|wr0_addr_in);
  assign wr1_ok    = wr1_en_in & (|wr1_addr_in);
  assign issue_set = issue_valid_in & ~stall_out & issue_rd_we_in;

  for (genvar r = 0; r < NREG; r++) begin : g_reg
    if (r == 0) begin : g_zero
      assign regs[r] = '0;
      assign busy[r] = 1'b0;
      assign clr[r]  = 1'b0;
    end else begin : g_ent
      logic hit0, hit1;
      assign hit0   = wr0_ok && (wr0_addr_in == ADDR_W'(r));
      assign hit1   = wr1_ok && (wr1_addr_in == ADDR_W'(r));
      assign clr[r] = hit0 | hit1;
      msrv32_rf_entry #(.XLEN(XLEN)) u_ent (
        .clk_i   (clk_in),
        .rst_i   (reset_in),
        .we_i    (hit0 | hit1),
        .wdata_i (hit1 ? wr1_data_in : wr0_data_in),
        .clr_i   (clr[r]),
        .set_i   (issue_set && (issue_rd_addr_in == ADDR_W'(r))),
        .data_o  (regs[r]),
        .busy_o  (busy[r])
      );
    end
  end

`ifdef MSRV32_RF_BYPASS_EN
  assign eff_busy = busy & ~clr;
`else
  assign eff_busy = busy;
`endif

  assign stall_out = issue_valid_in &
                     ((rs_1_used_in   & eff_busy[rs_1_addr_in]) |
                      (rs_2_used_in   & eff_busy[rs_2_addr_in]) |
                      (issue_rd_we_in & eff_busy[issue_rd_addr_in]));

  always_comb begin
    rs_1_out = regs[rs_1_addr_in];
    rs_2_out = regs[rs_2_addr_in];
`ifdef MSRV32_RF_BYPASS_EN
    // wrN_ok already excludes x0, so a forwarded value never reaches address 0.
    if (wr1_ok && wr1_addr_in == rs_1_addr_in)      rs_1_out = wr1_data_in;
    else if (wr0_ok && wr0_addr_in == rs_1_addr_in) rs_1_out = wr0_data_in;
    if (wr1_ok && wr1_addr_in == rs_2_addr_in)      rs_2_out = wr1_data_in;
    else if (wr0_ok && wr0_addr_in == rs_2_addr_in) rs_2_out = wr0_data_in;
`endif
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall_out && cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign busy_out        = busy;
  assign stall_count_out = cnt_q;
endmodule

// File: tb/tb_msrv32_reg_file_sb.sv
// Directed table-driven bench for msrv32_reg_file_sb, plus hand-written multi-cycle sequences.
module tb_msrv32_reg_file_sb;
`ifdef MSRV32_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1;
  logic [4:0]  rs1, rs2, rd, w0a, w1a;
  logic        u1, u2, iv, iwe, w0e, w1e;
  logic [31:0] w0d, w1d;
  logic [31:0] o_rs1, o_rs2, o_busy, o_cnt;
  logic        o_stall;

  always #5 clk = ~clk;

  msrv32_reg_file_sb #(.XLEN(32), .ADDR_W(5)) dut (
    .clk_in(clk), .reset_in(rst),
    .rs_1_addr_in(rs1), .rs_2_addr_in(rs2), .rs_1_used_in(u1), .rs_2_used_in(u2),
    .rs_1_out(o_rs1), .rs_2_out(o_rs2),
    .issue_valid_in(iv), .issue_rd_we_in(iwe), .issue_rd_addr_in(rd), .stall_out(o_stall),
    .wr0_en_in(w0e), .wr0_addr_in(w0a), .wr0_data_in(w0d),
    .wr1_en_in(w1e), .wr1_addr_in(w1a), .wr1_data_in(w1d),
    .busy_out(o_busy), .stall_count_out(o_cnt)
  );

  typedef struct {
    logic [4:0] rs1, rs2; logic u1, u2, iv, iwe; logic [4:0] rd;
    logic w0e; logic [4:0] w0a; logic [31:0] w0d;
    logic w1e; logic [4:0] w1a; logic [31:0] w1d;
    logic [31:0] e_rs1, e_rs2; logic e_stall; logic [31:0] e_busy, e_cnt;
  } vec_t;

  int nchk = 0, nfail = 0;
  vec_t tv[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] a1, a2, input logic x1, x2, v, we,
                              input logic [4:0] d, input logic e0, input logic [4:0] a0,
                              input logic [31:0] d0, input logic e1, input logic [4:0] a1w,
                              input logic [31:0] d1, input logic [31:0] r1, r2,
                              input logic s, input logic [31:0] b, c);
    vec_t t;
    t.rs1 = a1; t.rs2 = a2; t.u1 = x1; t.u2 = x2; t.iv = v; t.iwe = we; t.rd = d;
    t.w0e = e0; t.w0a = a0; t.w0d = d0; t.w1e = e1; t.w1a = a1w; t.w1d = d1;
    t.e_rs1 = r1; t.e_rs2 = r2; t.e_stall = s; t.e_busy = b; t.e_cnt = c;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    rs1 = t.rs1; rs2 = t.rs2; u1 = t.u1; u2 = t.u2; iv = t.iv; iwe = t.iwe; rd = t.rd;
    w0e = t.w0e; w0a = t.w0a; w0d = t.w0d; w1e = t.w1e; w1a = t.w1a; w1d = t.w1d;
  endtask

  // Idle cycle with only read addresses set; expectations are ignored by callers.
  function automatic vec_t rdv(input logic [4:0] a1, a2);
    return mk(a1, a2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t;
    int ecnt;
    //         rs1 rs2 u1 u2 iv we rd  w0e w0a w0d          w1e w1a w1d   e_rs1        e_rs2        st  busy   cnt
    tv[0]  = mk(1, 31, 0, 0, 0, 0, 0,  0, 0, 0,            0, 0, 0,      0,           0,           0, 0,     0);
    tv[1]  = mk(3, 4,  0, 0, 0, 0, 0,  1, 1, 32'hA5A50001, 1, 2, 32'h2,  0,           0,           0, 0,     0);
    tv[2]  = mk(1, 2,  1, 1, 1, 1, 5,  0, 0, 0,            0, 0, 0,      32'hA5A50001, 32'h2,      0, 0,     0);
    tv[3]  = mk(5, 1,  1, 1, 1, 0, 0,  0, 0, 0,            0, 0, 0,      0,           32'hA5A50001, 1, 32'h20, 0);
    tv[4]  = mk(5, 1,  1, 1, 0, 0, 0,  0, 0, 0,            0, 0, 0,      0,           32'hA5A50001, 0, 32'h20, 1);
    tv[5]  = mk(1, 2,  0, 0, 1, 1, 5,  0, 0, 0,            0, 0, 0,      32'hA5A50001, 32'h2,      1, 32'h20, 1);
    tv[6]  = mk(0, 0,  1, 1, 1, 1, 0,  1, 0, 32'h1234,     0, 0, 0,      0,           0,           0, 32'h20, 2);
    tv[7]  = mk(0, 0,  1, 1, 0, 0, 0,  0, 0, 0,            0, 0, 0,      0,           0,           0, 32'h20, 2);
    tv[8]  = mk(5, 5,  0, 0, 1, 1, 6,  0, 0, 0,            0, 0, 0,      0,           0,           0, 32'h20, 2);
    tv[9]  = mk(1, 6,  0, 1, 1, 0, 0,  0, 0, 0,            0, 0, 0,      32'hA5A50001, 0,          1, 32'h60, 2);
    tv[10] = mk(2, 1,  0, 0, 0, 0, 0,  0, 0, 0,            0, 0, 0,      32'h2,       32'hA5A50001, 0, 32'h60, 3);

    drive(rdv(0, 0));
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      drive(tv[i]);
      #1;
      chk($sformatf("v%0d_rs1", i),   o_rs1,   tv[i].e_rs1);
      chk($sformatf("v%0d_rs2", i),   o_rs2,   tv[i].e_rs2);
      chk($sformatf("v%0d_stall", i), {31'd0, o_stall}, {31'd0, tv[i].e_stall});
      chk($sformatf("v%0d_busy", i),  o_busy,  tv[i].e_busy);
      chk($sformatf("v%0d_cnt", i),   o_cnt,   tv[i].e_cnt);
      @(negedge clk);
    end

    // x5 write-back while a consumer of x5 waits at issue
    t = rdv(5, 0); t.u1 = 1; t.iv = 1; t.w0e = 1; t.w0a = 5; t.w0d = 32'hDEADBEEF;
    drive(t); #1;
    chk("wb_rs1",   o_rs1, BYP ? 32'hDEADBEEF : 32'h0);
    chk("wb_stall", {31'd0, o_stall}, BYP ? 32'd0 : 32'd1);
    ecnt = BYP ? 3 : 4;
    @(negedge clk);
    t.w0e = 0; drive(t); #1;
    chk("wb2_rs1",   o_rs1, 32'hDEADBEEF);
    chk("wb2_stall", {31'd0, o_stall}, 32'd0);
    chk("wb2_busy",  o_busy, 32'h40);
    chk("wb2_cnt",   o_cnt, ecnt);
    @(negedge clk);
    t = rdv(0, 0); t.w1e = 1; t.w1a = 6; t.w1d = 32'h66; drive(t);
    @(negedge clk);
    drive(rdv(6, 0)); #1;
    chk("x6_busy", o_busy, 32'h0);
    chk("x6_rd",   o_rs1, 32'h66);

    // both ports write x7 in one cycle: port 1 wins
    @(negedge clk);
    t = rdv(0, 0); t.iv = 1; t.iwe = 1; t.rd = 7; drive(t); #1;
    chk("x7_issue_stall", {31'd0, o_stall}, 32'd0);
    @(negedge clk);
    t = rdv(7, 7); t.w0e = 1; t.w0a = 7; t.w0d = 32'h11; t.w1e = 1; t.w1a = 7; t.w1d = 32'h22;
    drive(t); #1;
    chk("x7_byp_rs1", o_rs1, BYP ? 32'h22 : 32'h0);
    chk("x7_busy_pre", o_busy, 32'h80);
    @(negedge clk);
    drive(rdv(7, 7)); #1;
    chk("x7_rs1", o_rs1, 32'h22);
    chk("x7_rs2", o_rs2, 32'h22);
    chk("x7_busy", o_busy, 32'h0);

    // write-back and issue of x3 in the same cycle: set wins
    @(negedge clk);
    t = rdv(0, 0); t.iv = 1; t.iwe = 1; t.rd = 3; t.w0e = 1; t.w0a = 3; t.w0d = 32'h33;
    drive(t); #1;
    chk("x3_stall", {31'd0, o_stall}, 32'd0);
    @(negedge clk);
    drive(rdv(3, 0)); #1;
    chk("x3_busy", o_busy, 32'h08);
    chk("x3_rd",   o_rs1, 32'h33);

    // reset mid-stall with a concurrent write to x9
    @(negedge clk);
    t = rdv(0, 0); t.iv = 1; t.iwe = 1; t.rd = 9; drive(t); #1;
    chk("x9_issue_stall", {31'd0, o_stall}, 32'd0);
    @(negedge clk);
    t = rdv(9, 0); t.iv = 1; t.u1 = 1; t.w0e = 1; t.w0a = 9; t.w0d = 32'h99;
    drive(t); rst = 1'b1; #1;
    chk("x9_stall", {31'd0, o_stall}, BYP ? 32'd0 : 32'd1);
    chk("x9_busy_pre", o_busy, 32'h208);
    @(negedge clk);
    rst = 1'b0;
    t = rdv(9, 3); t.iv = 1; t.u1 = 1; drive(t); #1;
    chk("rst_busy",  o_busy, 32'h0);
    chk("rst_cnt",   o_cnt, 32'h0);
    chk("rst_x9",    o_rs1, 32'h0);
    chk("rst_x3",    o_rs2, 32'h0);
    chk("rst_stall", {31'd0, o_stall}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end
endmodule
